// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined lab ALU: one-hot op bit positions and the
// flag bundle that travels with each result through the output stage.
package alu_pkg;

  localparam int unsigned OP_W    = 12;
  localparam int unsigned OP_ADD  = 11;
  localparam int unsigned OP_SUB  = 10;
  localparam int unsigned OP_SLT  = 9;
  localparam int unsigned OP_SLTU = 8;
  localparam int unsigned OP_AND  = 7;
  localparam int unsigned OP_NOR  = 6;
  localparam int unsigned OP_OR   = 5;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_SLL  = 3;
  localparam int unsigned OP_SRL  = 2;
  localparam int unsigned OP_SRA  = 1;
  localparam int unsigned OP_LUI  = 0;

  localparam logic [OP_W-1:0] OP_ONE = OP_W'(1);

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic err;
  } alu_flags_t;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic is_onehot(input logic [OP_W-1:0] op);
    return (op != '0) && ((op & (op - OP_ONE)) == '0);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath of the lab ALU: result plus zero/carry/overflow/error flags
// for one one-hot operation on WIDTH-bit operands.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             err_o
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned Half = WIDTH / 2;

  logic             legal;
  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [ShW-1:0]   shamt;
  logic             add_ovf;
  logic             lt_s;
  logic             lt_u;

  assign legal  = is_onehot(op_i);
  assign sub_op = op_i[OP_SUB];
  assign b_eff  = sub_op ? ~b_i : b_i;
  // Shared adder: subtraction is A + ~B + 1, so the carry-in is the sub select.
  assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
  assign shamt  = a_i[ShW-1:0];

  assign add_ovf = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  assign lt_s    = $signed(a_i) < $signed(b_i);
  assign lt_u    = a_i < b_i;

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    ovf_o    = 1'b0;
    if (legal) begin
      unique case (1'b1)
        op_i[OP_ADD]: begin
          result_o = sum[WIDTH-1:0];
          carry_o  = sum[WIDTH];
          ovf_o    = add_ovf;
        end
        op_i[OP_SUB]: begin
          result_o = sum[WIDTH-1:0];
          carry_o  = ~sum[WIDTH];
          ovf_o    = add_ovf;
        end
        op_i[OP_SLT]:  result_o = {{(WIDTH-1){1'b0}}, lt_s};
        op_i[OP_SLTU]: result_o = {{(WIDTH-1){1'b0}}, lt_u};
        op_i[OP_AND]:  result_o = a_i & b_i;
        op_i[OP_NOR]:  result_o = ~(a_i | b_i);
        op_i[OP_OR]:   result_o = a_i | b_i;
        op_i[OP_XOR]:  result_o = a_i ^ b_i;
        op_i[OP_SLL]:  result_o = b_i << shamt;
        op_i[OP_SRL]:  result_o = b_i >> shamt;
        op_i[OP_SRA]:  result_o = $signed(b_i) >>> shamt;
        op_i[OP_LUI]:  result_o = {b_i[Half-1:0], {Half{1'b0}}};
        default: ;
      endcase
    end
  end

  assign zero_o = (result_o == '0);
  assign err_o  = !legal;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined lab ALU with valid/ready flow control and full backpressure. An optional
// operand stage (S1) feeds the ALU core, whose result and flags land in the output stage (S2).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  alu_control,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_err,
  output logic [1:0]       busy_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    alu_flags_t       flags;
  } stage_t;

  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : gen_bad_stages
    $error("alu_pipe: PIPE_STAGES must be 1 or 2");
  end
  if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 2) != 0) begin : gen_bad_width
    $error("alu_pipe: WIDTH must be even and within 8..64");
  end

  logic             s2_ready;
  logic             s2_valid_q;
  stage_t           s2_q;
  stage_t           s2_d;
  logic             feed_valid;
  logic             s1_busy;
  logic [OP_W-1:0]  core_op;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_carry;
  logic             core_ovf;
  logic             core_err;

  assign s2_ready = !s2_valid_q || out_ready;

  if (PIPE_STAGES == 2) begin : gen_s1
    logic             s1_valid_q;
    logic             s1_ready;
    logic [OP_W-1:0]  s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;

    assign s1_ready = !s1_valid_q || s2_ready;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_valid_q <= 1'b0;
        s1_op_q    <= '0;
        s1_a_q     <= '0;
        s1_b_q     <= '0;
      end else if (s1_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_op_q <= alu_control;
          s1_a_q  <= alu_src1;
          s1_b_q  <= alu_src2;
        end
      end
    end

    assign in_ready   = s1_ready;
    assign feed_valid = s1_valid_q;
    assign s1_busy    = s1_valid_q;
    assign core_op    = s1_op_q;
    assign core_a     = s1_a_q;
    assign core_b     = s1_b_q;
  end else begin : gen_no_s1
    // Single-stage: the core sits between the input port and the output registers.
    assign in_ready   = s2_ready;
    assign feed_valid = in_valid;
    assign s1_busy    = 1'b0;
    assign core_op    = alu_control;
    assign core_a     = alu_src1;
    assign core_b     = alu_src2;
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op_i    (core_op),
    .a_i     (core_a),
    .b_i     (core_b),
    .result_o(core_result),
    .zero_o  (core_zero),
    .carry_o (core_carry),
    .ovf_o   (core_ovf),
    .err_o   (core_err)
  );

  always_comb begin
    s2_d             = '0;
    s2_d.result      = core_result;
    s2_d.flags.zero  = core_zero;
    s2_d.flags.carry = core_carry;
    s2_d.flags.ovf   = core_ovf;
    s2_d.flags.err   = core_err;
  end

  // Output registers only load on an incoming beat, so a stalled result stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else if (s2_ready) begin
      s2_valid_q <= feed_valid;
      if (feed_valid) begin
        s2_q <= s2_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign alu_result = s2_q.result;
  assign flag_zero  = s2_q.flags.zero;
  assign flag_carry = s2_q.flags.carry;
  assign flag_ovf   = s2_q.flags.ovf;
  assign flag_err   = s2_q.flags.err;
  assign busy_cnt   = {1'b0, s1_busy} + {1'b0, s2_valid_q};

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the lab ALU that currently sits behind the LCD display wrapper.
- Computes the 12 Loongson-lab operations on WIDTH-bit operands and produces zero/carry/overflow/error flags.
- Uses a valid/ready handshake with full backpressure, so a display or CPU front end can stream operations through it.
- Latency is PIPE_STAGES cycles, selectable at elaboration.

Parameters:
- WIDTH, 32: operand and result width; legal values 8..64, must be even.
- PIPE_STAGES, 2: number of register stages, 1 or 2. Any other value is an elaboration error.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/op beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- alu_control  in  12  one-hot op: [11] add, [10] sub, [9] slt, [8] sltu, [7] and, [6] nor, [5] or, [4] xor, [3] sll, [2] srl, [1] sra, [0] lui.
- alu_src1  in  WIDTH  operand A; also the shift amount.
- alu_src2  in  WIDTH  operand B; also the value being shifted.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- alu_result  out  WIDTH  result.
- flag_zero  out  1  alu_result == 0.
- flag_carry  out  1  add: carry out; sub: borrow (A <u B); 0 for all other ops.
- flag_ovf  out  1  signed overflow for add/sub; 0 for all other ops.
- flag_err  out  1  alu_control not exactly one-hot.
- busy_cnt  out  2  number of beats currently held in the pipe (0..PIPE_STAGES).

Behaviour:
- Reset (asserted asynchronously, released synchronously to clk): all valid bits 0, busy_cnt 0, alu_result 0, all flags 0; in_ready is 1 one cycle after reset deasserts.
- A beat transfers on input when in_valid && in_ready; on output when out_valid && out_ready.
- Stage structure, PIPE_STAGES=2:
  - S1 registers op, A and B.
  - S2 registers the computed result and flags.
  - Latency: first accept to out_valid is 2 cycles.
- Stage structure, PIPE_STAGES=1: only S2 exists; out_valid follows the accept by 1 cycle.
- Stall logic, per stage: stage_ready = !stage_valid || next_ready. The last stage's next_ready is out_ready, and in_ready = the first stage's ready.
  - Full throughput: 1 beat per cycle when out_ready is held high.
  - No combinational path from in_valid to out_valid.
- Held stage: while out_valid && !out_ready, the output registers hold alu_result and all flags stable.
- Arithmetic:
  - add/sub use a WIDTH+1-bit adder; sub is A + ~B + 1.
  - carry is the adder MSB for add and the inverted MSB for sub.
  - ovf = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is B for add and ~B for sub.
- Compares: slt gives 1 if signed A<B, else 0. sltu gives the unsigned compare. The result is zero-extended.
- Shifts use shamt = A[$clog2(WIDTH)-1:0]:
  - sll = B<<shamt
  - srl = B>>shamt (logical)
  - sra = arithmetic right shift of B
- lui: {B[WIDTH/2-1:0], WIDTH/2 zeros}.
- Illegal op (zero or more than one bit set): result 0, flag_zero 1, flag_err 1, carry/ovf 0. The beat still flows through and is never dropped.
- Simultaneous accept and emit: busy_cnt is unchanged. Accept only: +1. Emit only: −1.
- Reset mid-operation: in-flight beats are discarded and no out_valid pulse follows.
- Flags are registered alongside the result in the same stage and are never computed from registered outputs.

Decomposition:
- Package alu_pkg holds:
  - op bit-index localparams (OP_ADD=11 … OP_LUI=0) and OP_W=12;
  - a struct/packed bundle {result, zero, carry, ovf, err} for the stage payload.
- One combinational sub-module, alu_core (WIDTH), computes result and flags from op, A and B.
- alu_pipe contains only the handshake/stage registers plus one alu_core instance.

Test Plan:
- Reset, then stream add A=0x7FFFFFFF, B=1 with out_ready=1 -> after 2 cycles alu_result=0x80000000, ovf=1, carry=0, zero=0.
- sub A=3, B=5, then sltu A=3, B=5, then slt A=0xFFFFFFFF, B=1, back-to-back -> 0xFFFFFFFE carry=1; then 1; then 1; then in consecutive cycles, in_ready held 1 throughout.
- sra A=4, B=0x80000000 -> 0xF8000000. srl with the same operands -> 0x08000000. lui B=0x1234 -> 0x12340000.
- Hold out_ready=0 for 5 cycles while driving 3 beats -> in_ready falls after 2 accepts, busy_cnt=2, alu_result stable. Release -> results emerge in order with no loss or duplication.
- alu_control=12'h000, then 12'h801 -> two beats, each with result 0, flag_err=1, flag_zero=1.
- Assert reset with 2 beats in flight -> out_valid=0 and busy_cnt=0 immediately. Repeat all cases at WIDTH=16 with PIPE_STAGES=1 and check 1-cycle latency.
